// File: rtl/seg7_pkg.sv
// seg7_pkg -- definitions shared by the 7-segment scanner and the stopwatch.
//   SEG_BLANK / SEG_ZERO : active-low {a..g} codes for "all off" and "0"
//   scan_state_t         : blanking / lit phase of a digit slot
//   digit_idx_t          : 2-bit digit index (0 = sec1 .. 3 = min2)
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_LIT   = 1'b1
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_LAST = 2'd3;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [3:0] anode_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer -- digit slot counter plus digit index for the scanner.
//   clk, rst    : clock, asynchronous active-low reset
//   count       : position inside the current slot, 0..SCAN_DIV-1
//   index       : digit being scanned, 0..3
//   slot_wrap   : high on the last cycle of every slot
//   frame_wrap  : high on the last cycle of the digit-3 slot
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50_000,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output digit_idx_t    index,
  output logic          slot_wrap,
  output logic          frame_wrap
);

  assign slot_wrap  = (count == CW'(SCAN_DIV - 1));
  assign frame_wrap = slot_wrap && (index == DIGIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      index <= '0;
    end else if (slot_wrap) begin
      count <= '0;
      index <= index + 2'd1;  // 3 rolls over to 0 naturally
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed driver for a 4-digit common-anode display.
//   clk, rst            : clock, asynchronous active-low reset
//   sec1..min2          : active-low segment codes from the stopwatch
//   tick                : one-second toggle, shown on the colon (digit 2 dp)
//   hold                : freeze the displayed snapshot
//   dim                 : halve the lit part of every slot
//   seg, an, dp         : registered active-low display drive
//   frame_done          : pulse on the last cycle of the digit-3 slot
// Each slot starts with BLANK_CYC blanking cycles so the previous digit's
// segments never ghost onto the newly selected anode.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_CYC = 16,
  parameter int BLANK_LZ  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec1,
  input  logic [6:0] sec2,
  input  logic [6:0] min1,
  input  logic [6:0] min2,
  input  logic       tick,
  input  logic       hold,
  input  logic       dim,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW      = $clog2(SCAN_DIV);
  // First slot count that is dark when dimming.
  localparam int DIM_END = BLANK_CYC + (SCAN_DIV - BLANK_CYC) / 2;

  logic [CW-1:0] count;
  digit_idx_t    index;
  logic          slot_wrap;
  logic          frame_wrap;

  scan_state_t   state;
  logic [6:0]    snap [4];
  logic          tick_reg;

  logic          in_window;
  logic          lz_blank;
  logic          lit;

  seg7_slot_timer #(
    .SCAN_DIV (SCAN_DIV),
    .CW       (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .index      (index),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap)
  );

  assign frame_done = frame_wrap;

  always_comb begin
    in_window = (state == ST_LIT) && (!dim || (count < CW'(DIM_END)));
    lz_blank  = (BLANK_LZ != 0) && (index == DIGIT_LAST) && (snap[3] == SEG_ZERO);
    lit       = in_window && !lz_blank;
  end

  // State is advanced one cycle early (at BLANK_CYC-1) so that it is LIT
  // exactly while count >= BLANK_CYC; the pins then follow one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BLANK;
      snap[0]  <= SEG_BLANK;
      snap[1]  <= SEG_BLANK;
      snap[2]  <= SEG_BLANK;
      snap[3]  <= SEG_BLANK;
      tick_reg <= 1'b0;
      seg      <= SEG_BLANK;
      an       <= 4'b1111;
      dp       <= 1'b1;
    end else begin
      tick_reg <= tick;

      case (state)
        ST_BLANK: if (count == CW'(BLANK_CYC - 1)) state <= ST_LIT;
        ST_LIT:   if (slot_wrap)                   state <= ST_BLANK;
        default:                                   state <= ST_BLANK;
      endcase

      // Capture all four digits together so a frame never mixes two readings.
      if (frame_wrap && !hold) begin
        snap[0] <= sec1;
        snap[1] <= sec2;
        snap[2] <= min1;
        snap[3] <= min2;
      end

      if (lit) begin
        seg <= snap[index];
        an  <= anode_sel(index);
        dp  <= !((index == 2'd2) && tick_reg);
      end else begin
        seg <= SEG_BLANK;
        an  <= 4'b1111;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- scoreboard bench for seg7_scan with a small display model.
module tb_seg7_scan;
  import seg7_pkg::*;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int BLANK_LZ  = 1;
  localparam int FRAME     = 4 * SCAN_DIV;
  localparam int DIM_END   = BLANK_CYC + (SCAN_DIV - BLANK_CYC) / 2;

  localparam logic [6:0] CODE_ONE  = 7'b1001111;
  localparam logic [6:0] CODE_NINE = 7'b0000100;
  localparam logic [6:0] CODE_FIVE = 7'b0100100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] sec1, sec2, min1, min2;
  logic       tick, hold, dim;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_done;

  always #5 clk = ~clk;

  seg7_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .BLANK_LZ  (BLANK_LZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec1       (sec1),
    .sec2       (sec2),
    .min1       (min1),
    .min2       (min2),
    .tick       (tick),
    .hold       (hold),
    .dim        (dim),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       an_dc;  // digit 3 lit with a blank snapshot: anode not checked
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         t;           // cycles since reset release = model timebase
  logic [6:0] m_snap [4];
  logic       m_tickr;
  int         fd_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, act, exp);
    end
  endtask

  // What the pins must show one cycle after the cycle at model time t.
  function automatic exp_t model_pins();
    int   cnt, idx;
    logic lit;
    exp_t e;
    cnt = t % SCAN_DIV;
    idx = (t / SCAN_DIV) % 4;
    lit = (cnt >= BLANK_CYC) && (!dim || cnt < DIM_END);
    if (BLANK_LZ == 1 && idx == 3 && m_snap[3] == SEG_ZERO) lit = 1'b0;
    e.seg = lit ? m_snap[idx] : SEG_BLANK;
    e.an  = 4'hF;
    if (lit) e.an[idx] = 1'b0;
    e.dp    = !(lit && idx == 2 && m_tickr);
    e.an_dc = lit && idx == 3 && m_snap[3] == SEG_BLANK;
    return e;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = SEG_BLANK;
    m_tickr = 1'b0;
    sb_q.delete();
  endtask

  // One clock: check frame_done now, queue expected pins, clock, compare.
  task automatic cycle();
    exp_t e;
    chk("frame_done", {31'd0, frame_done}, {31'd0, (t % FRAME) == FRAME - 1});
    if (frame_done) fd_seen++;
    sb_q.push_back(model_pins());
    @(posedge clk);
    if ((t % FRAME) == FRAME - 1 && !hold) begin
      m_snap[0] = sec1;
      m_snap[1] = sec2;
      m_snap[2] = min1;
      m_snap[3] = min2;
    end
    m_tickr = tick;
    t++;
    #1;
    e = sb_q.pop_front();
    chk("seg", {25'd0, seg}, {25'd0, e.seg});
    if (!e.an_dc) chk("an", {28'd0, an}, {28'd0, e.an});
    chk("dp", {31'd0, dp}, {31'd0, e.dp});
    chk("an_onecold", {31'd0, $countones(~an) <= 1}, 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"},  {28'd0, an},         32'hF);
    chk({tag, "_seg"}, {25'd0, seg},        32'h7F);
    chk({tag, "_dp"},  {31'd0, dp},         32'd1);
    chk({tag, "_fd"},  {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    sec1 = SEG_ZERO; sec2 = SEG_ZERO; min1 = SEG_ZERO; min2 = SEG_ZERO;
    tick = 1'b0; hold = 1'b0; dim = 1'b0;
    t = 0;
    fd_seen = 0;

    // Reset state, then release away from the clock edge.
    repeat (3) @(posedge clk);
    #1;
    chk_blank("reset");
    rst = 1'b1;
    model_reset();

    // Frame 1 shows blank snapshots, frame 2 the captured zeros (LZ on digit 3).
    run(2 * FRAME);

    // Minutes-tens "1": digit 3 lit after the next capture; frame_done rate.
    min2 = CODE_ONE;
    fd_seen = 0;
    run(2 * FRAME);
    chk("fd_per_2_frames", fd_seen, 32'd2);

    // Dim window.
    dim = 1'b1;
    run(FRAME);
    dim = 1'b0;

    // Colon on / off.
    tick = 1'b1;
    run(FRAME);
    tick = 1'b0;
    run(FRAME);

    // Hold freezes sec1 across several captures, release shows it later.
    hold = 1'b1;
    run(5);
    sec1 = CODE_NINE;
    run(3 * FRAME);
    hold = 1'b0;
    run(2 * FRAME);

    // Mid-frame input change stays hidden until the next capture.
    run(10);
    sec2 = CODE_FIVE;
    run(2 * FRAME);

    // Random mix of controls and codes.
    for (int i = 0; i < 6 * FRAME; i++) begin
      case ($urandom_range(0, 15))
        0: dim  = ~dim;
        1: tick = ~tick;
        2: hold = ~hold;
        3: sec1 = 7'($urandom);
        4: min2 = ($urandom_range(0, 1) == 1) ? SEG_ZERO : 7'($urandom);
        5: min1 = 7'($urandom);
        default: ;
      endcase
      cycle();
    end
    dim = 1'b0; hold = 1'b0; tick = 1'b1;

    // Asynchronous reset at count 4 of digit 2.
    while ((t % FRAME) != 2 * SCAN_DIV + 4) cycle();
    rst = 1'b0;
    #1;
    chk_blank("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_blank("in_rst");
    rst = 1'b1;
    model_reset();
    run(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
